// File: rtl/perip_timecmp.sv
// perip_timecmp: 64-bit compare/interrupt controller for the free-running microsecond timer.
// Arms on a complete compare write and fires one-shot or with periodic reload.
module perip_timecmp #(
  parameter int unsigned MISS_W   = 8,
  parameter int unsigned DATA_BUS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                rw,
  input  logic [DATA_BUS-1:0] addr,
  output logic [DATA_BUS-1:0] rdata,
  input  logic [DATA_BUS-1:0] wdata,
  input  logic [63:0]         time_us,
  output logic                irq
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StArmed = 2'd1;
  localparam logic [1:0] StFire  = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [63:0]         cmp_q, cmp_d;
  logic [31:0]         period_q;
  logic                en_q, periodic_q, ie_q;
  logic                fired_q, fired_d;
  logic [MISS_W-1:0]   missed_q, missed_d;
  logic [DATA_BUS-1:0] rdata_q, rd_val, status_val;
  logic                irq_q;

  logic [2:0] sel;
  logic       wr_en, rd_en;
  logic       wr_lo, wr_hi, wr_per, wr_ctrl, wr_stat, wr_cfg, w1c;
  logic       fire;
  logic       unused_addr;

  assign sel     = addr[4:2];
  assign wr_en   = ena & rw;
  assign rd_en   = ena & ~rw;
  assign wr_lo   = wr_en & (sel == 3'd0);
  assign wr_hi   = wr_en & (sel == 3'd1);
  assign wr_per  = wr_en & (sel == 3'd2);
  assign wr_ctrl = wr_en & (sel == 3'd3);
  assign wr_stat = wr_en & (sel == 3'd4);
  assign wr_cfg  = wr_lo | wr_hi | wr_ctrl;
  assign w1c     = wr_stat & wdata[0];

  assign unused_addr = ^{addr[DATA_BUS-1:5], addr[1:0]};

  always_comb begin
    state_d = state_q;
    cmp_d   = cmp_q;
    fire    = 1'b0;
    case (state_q)
      StArmed: begin
        if (time_us >= cmp_q) begin
          fire    = 1'b1;
          state_d = StFire;
        end
      end
      StFire: begin
        if (periodic_q && (period_q != '0)) begin
          cmp_d   = cmp_q + {32'd0, period_q};
          state_d = StArmed;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A compare/control write overrides both a match and a pending reload.
    if (wr_cfg) begin
      fire    = 1'b0;
      cmp_d   = cmp_q;
      state_d = (state_q == StFire) ? StIdle : state_q;
      if (wr_lo) begin
        cmp_d[31:0] = wdata[31:0];
        state_d     = StIdle;
      end
      if (wr_hi) begin
        cmp_d[63:32] = wdata[31:0];
        state_d      = en_q ? StArmed : StIdle;
      end
      if (wr_ctrl) begin
        if (!wdata[0]) begin
          state_d = StIdle;
        end else if (!en_q) begin
          state_d = StArmed;
        end
      end
    end
  end

  always_comb begin
    fired_d  = fired_q;
    missed_d = missed_q;
    if (w1c) begin
      fired_d  = 1'b0;
      missed_d = '0;
    end
    if (fire) begin
      fired_d = 1'b1;
      if (fired_q && !w1c && (missed_q != '1)) begin
        missed_d = missed_q + MISS_W'(1);
      end
    end
  end

  always_comb begin
    status_val              = '0;
    status_val[0]           = fired_q;
    status_val[1]           = (state_q == StArmed);
    status_val[8 +: MISS_W] = missed_q;
    case (sel)
      3'd0:    rd_val = cmp_q[31:0];
      3'd1:    rd_val = cmp_q[63:32];
      3'd2:    rd_val = period_q;
      3'd3:    rd_val = {29'd0, ie_q, periodic_q, en_q};
      3'd4:    rd_val = status_val;
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cmp_q      <= '0;
      period_q   <= '0;
      en_q       <= 1'b0;
      periodic_q <= 1'b0;
      ie_q       <= 1'b0;
      fired_q    <= 1'b0;
      missed_q   <= '0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmp_q    <= cmp_d;
      fired_q  <= fired_d;
      missed_q <= missed_d;
      irq_q    <= fired_q & ie_q;
      if (wr_per) begin
        period_q <= wdata[31:0];
      end
      if (wr_ctrl) begin
        en_q       <= wdata[0];
        periodic_q <= wdata[1];
        ie_q       <= wdata[2];
      end
      if (rd_en) begin
        rdata_q <= rd_val;
      end
    end
  end

  assign rdata = rdata_q;
  assign irq   = irq_q;

endmodule

// File: tb/tb_perip_timecmp.sv
// Self-checking bench for perip_timecmp: scenario tasks with a queue of expected read/irq values.
module tb_perip_timecmp;

  logic        clk = 1'b0;
  logic        rst, ena, rw;
  logic [31:0] addr, rdata, wdata;
  logic [63:0] time_us;
  logic        irq;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got, exp_v;

  perip_timecmp #(
    .MISS_W  (8),
    .DATA_BUS(32)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .rw     (rw),
    .addr   (addr),
    .rdata  (rdata),
    .wdata  (wdata),
    .time_us(time_us),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timed out");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input int idx, input logic [31:0] d);
    ena   = 1'b1;
    rw    = 1'b1;
    addr  = 32'(idx << 2);
    wdata = d;
    tick();
    ena   = 1'b0;
    rw    = 1'b0;
    wdata = '0;
  endtask

  task automatic bus_read(input int idx, output logic [31:0] q);
    ena  = 1'b1;
    rw   = 1'b0;
    addr = 32'(idx << 2);
    tick();
    ena  = 1'b0;
    q    = rdata;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    ena = 1'b0;
    rw  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b0; rw = 1'b0; addr = '0; wdata = '0; time_us = '0;
    tick();
    tick();
    exp_q.push_back(32'h0);
    got = {31'd0, irq};
    exp_v = exp_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL reset_irq: got %h expected %h", got, exp_v); end
    exp_q.push_back(32'h0);
    got = rdata;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL reset_rdata: got %h expected %h", got, exp_v); end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(32'h0);
      bus_read(i, got);
      exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin
        n_bad++; $display("FAIL reset_reg%0d: got %h expected %h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_one_shot();
    apply_reset();
    time_us = 64'd90;
    bus_write(3, 32'd5);
    bus_write(0, 32'd100);
    bus_write(1, 32'd0);
    for (int t = 90; t <= 100; t++) begin
      time_us = 64'(t);
      exp_q.push_back(32'h2);
      bus_read(4, got);
      exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin
        n_bad++; $display("FAIL oneshot_armed_t%0d: got %h expected %h", t, got, exp_v);
      end
    end
    exp_q.push_back(32'h0);
    got = {31'd0, irq};
    exp_v = exp_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL oneshot_irq_early: got %h expected %h", got, exp_v); end
    exp_q.push_back(32'h1);
    bus_read(4, got);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL oneshot_fired: got %h expected %h", got, exp_v); end
    exp_q.push_back(32'h1);
    got = {31'd0, irq};
    exp_v = exp_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL oneshot_irq: got %h expected %h", got, exp_v); end
    exp_q.push_back(32'h1);
    bus_read(4, got);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL oneshot_idle: got %h expected %h", got, exp_v); end
    bus_write(4, 32'h1);
    tick();
    exp_q.push_back(32'h0);
    got = {31'd0, irq};
    exp_v = exp_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL oneshot_irq_clr: got %h expected %h", got, exp_v); end
    exp_q.push_back(32'h0);
    bus_read(4, got);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL oneshot_status_clr: got %h expected %h", got, exp_v); end
  endtask

  task automatic test_periodic();
    int pts [3];
    pts = '{50, 60, 70};
    apply_reset();
    time_us = '0;
    bus_write(2, 32'd10);
    bus_write(0, 32'd50);
    bus_write(1, 32'd0);
    bus_write(3, 32'd7);
    for (int k = 0; k < 3; k++) begin
      for (int t = pts[k] - 2; t <= pts[k] + 1; t++) begin
        time_us = 64'(t);
        exp_q.push_back((t == pts[k] + 1) ? 32'h1 : 32'h2);
        bus_read(4, got);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (got !== exp_v) begin
          n_bad++; $display("FAIL periodic_status_t%0d: got %h expected %h", t, got, exp_v);
        end
      end
      time_us = 64'(pts[k] + 2);
      bus_write(4, 32'h1);
      exp_q.push_back(32'(pts[k] + 10));
      bus_read(0, got);
      exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin
        n_bad++; $display("FAIL periodic_cmp_lo_%0d: got %h expected %h", k, got, exp_v);
      end
      exp_q.push_back(32'h0);
      bus_read(1, got);
      exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin
        n_bad++; $display("FAIL periodic_cmp_hi_%0d: got %h expected %h", k, got, exp_v);
      end
    end
  endtask

  task automatic test_split_write();
    apply_reset();
    time_us = 64'h80;
    bus_write(0, 32'h0);
    bus_write(1, 32'h1);
    bus_write(3, 32'h1);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(32'h2);
      bus_read(4, got);
      exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_bad++; $display("FAIL split_armed: got %h expected %h", got, exp_v); end
    end
    bus_write(0, 32'h10);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'h0);
      bus_read(4, got);
      exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_bad++; $display("FAIL split_pending: got %h expected %h", got, exp_v); end
    end
    bus_write(1, 32'h1);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'h2);
      bus_read(4, got);
      exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_bad++; $display("FAIL split_rearmed: got %h expected %h", got, exp_v); end
    end
    // New low half alone would already be below time_us.
    bus_write(0, 32'h100);
    bus_write(1, 32'h0);
    bus_write(0, 32'h10);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'h0);
      bus_read(4, got);
      exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_bad++; $display("FAIL split_low_guard: got %h expected %h", got, exp_v); end
    end
    bus_write(1, 32'h1);
    exp_q.push_back(32'h2);
    bus_read(4, got);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL split_final: got %h expected %h", got, exp_v); end
  endtask

  task automatic test_missed();
    apply_reset();
    time_us = 64'd1000;
    bus_write(2, 32'd1);
    bus_write(0, 32'd0);
    bus_write(1, 32'd0);
    bus_write(3, 32'd3);
    repeat (600) tick();
    exp_q.push_back(32'hFF01);
    bus_read(4, got);
    got = got & 32'hFF01;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL missed_sat: got %h expected %h", got, exp_v); end
    repeat (20) tick();
    exp_q.push_back(32'hFF01);
    bus_read(4, got);
    got = got & 32'hFF01;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL missed_hold: got %h expected %h", got, exp_v); end
    bus_write(4, 32'h1);
    exp_q.push_back(32'h0);
    bus_read(4, got);
    got = got & 32'hFF00;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL missed_clr: got %h expected %h", got, exp_v); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.push_back(32'h0);
    bus_read(4, got);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL midrst_status: got %h expected %h", got, exp_v); end
    exp_q.push_back(32'h0);
    bus_read(0, got);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL midrst_cmp_lo: got %h expected %h", got, exp_v); end
  endtask

  task automatic test_collision();
    apply_reset();
    time_us = '0;
    bus_write(0, 32'd100);
    bus_write(1, 32'd0);
    bus_write(3, 32'd5);
    time_us = 64'd99;
    tick();
    time_us = 64'd100;
    bus_write(3, 32'd4);
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_q.push_back(32'h0);
      got = {31'd0, irq};
      exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_bad++; $display("FAIL collision_irq: got %h expected %h", got, exp_v); end
    end
    exp_q.push_back(32'h0);
    bus_read(4, got);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL collision_status: got %h expected %h", got, exp_v); end
    exp_q.push_back(32'h4);
    bus_read(3, got);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL collision_ctrl: got %h expected %h", got, exp_v); end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_periodic();
    test_split_write();
    test_missed();
    test_collision();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
